// File: rtl/duck_gfx_pkg.sv
// Shared sprite-path constants and types for the duck blitter and the scan-out side.
package duck_gfx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } blit_state_t;

    localparam int DUCK_SPR_W = 68;
    localparam int DUCK_SPR_H = 64;
    localparam int DUCK_FB_W  = 320;
    localparam int DUCK_FB_H  = 240;

    localparam logic [3:0] DUCK_TRANSPARENT_IDX = 4'h0;

    localparam int DUCK_PIX_W   = 4;
    localparam int DUCK_POS_W   = 10;
    localparam int DUCK_COORD_W = 11;
    localparam int DUCK_ROM_AW  = $clog2(DUCK_SPR_W * DUCK_SPR_H);
    localparam int DUCK_FB_AW   = $clog2(DUCK_FB_W * DUCK_FB_H);

endpackage

// File: rtl/duck_blit_addr.sv
// Combinational sprite-to-screen mapping: flip, offset, clip test and framebuffer address.
module duck_blit_addr
    import duck_gfx_pkg::*;
#(
    parameter int SPR_W = DUCK_SPR_W,
    parameter int SPR_H = DUCK_SPR_H,
    parameter int FB_W  = DUCK_FB_W,
    parameter int FB_H  = DUCK_FB_H
) (
    input  logic [DUCK_POS_W-1:0]          i_pos_x,
    input  logic [DUCK_POS_W-1:0]          i_pos_y,
    input  logic                           i_flip_h,
    input  logic [$clog2(SPR_W)-1:0]       i_sx,
    input  logic [$clog2(SPR_H)-1:0]       i_sy,
    output logic signed [DUCK_COORD_W-1:0] o_tx,
    output logic signed [DUCK_COORD_W-1:0] o_ty,
    output logic                           o_in_bounds,
    output logic [DUCK_FB_AW-1:0]          o_fb_addr
);

    localparam int SX_W = $clog2(SPR_W);
    localparam int SY_W = $clog2(SPR_H);
    localparam int CW   = DUCK_COORD_W;
    localparam int AW   = DUCK_FB_AW;

    localparam logic [CW-1:0] FB_W_C = CW'(FB_W);
    localparam logic [CW-1:0] FB_H_C = CW'(FB_H);
    localparam logic [AW-1:0] FB_W_A = AW'(FB_W);

    logic [SX_W-1:0] w_col;

    always_comb begin
        w_col = i_flip_h ? (SX_W'(SPR_W - 1) - i_sx) : i_sx;
        o_tx  = $signed({i_pos_x[DUCK_POS_W-1], i_pos_x})
              + $signed({{(CW - SX_W){1'b0}}, w_col});
        o_ty  = $signed({i_pos_y[DUCK_POS_W-1], i_pos_y})
              + $signed({{(CW - SY_W){1'b0}}, i_sy});
        // Sign bit rejects negative coordinates, so the upper bound compares unsigned.
        o_in_bounds = !o_tx[CW-1] && (unsigned'(o_tx) < FB_W_C)
                   && !o_ty[CW-1] && (unsigned'(o_ty) < FB_H_C);
        o_fb_addr = ({{(AW - CW){1'b0}}, o_ty} * FB_W_A) + {{(AW - CW){1'b0}}, o_tx};
    end

endmodule

// File: rtl/duck_sprite_blitter.sv
// Streams one sprite from the palette ROM into the framebuffer at one pixel per clock,
// skipping transparent and off-screen pixels.
module duck_sprite_blitter
    import duck_gfx_pkg::*;
#(
    parameter int         SPR_W           = DUCK_SPR_W,
    parameter int         SPR_H           = DUCK_SPR_H,
    parameter int         FB_W            = DUCK_FB_W,
    parameter int         FB_H            = DUCK_FB_H,
    parameter logic [3:0] TRANSPARENT_IDX = DUCK_TRANSPARENT_IDX
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [DUCK_POS_W-1:0]  pos_x,
    input  logic [DUCK_POS_W-1:0]  pos_y,
    input  logic                   flip_h,
    output logic [DUCK_ROM_AW-1:0] rom_address,
    input  logic [DUCK_PIX_W-1:0]  rom_q,
    output logic                   fb_we,
    output logic [DUCK_FB_AW-1:0]  fb_addr,
    output logic [DUCK_PIX_W-1:0]  fb_data,
    output logic                   busy,
    output logic                   done
);

    localparam int SX_W = $clog2(SPR_W);
    localparam int SY_W = $clog2(SPR_H);

    blit_state_t r_state;
    blit_state_t w_next;

    logic [SX_W-1:0]        r_sx;
    logic [SY_W-1:0]        r_sy;
    logic [DUCK_ROM_AW-1:0] r_addr;
    logic [DUCK_POS_W-1:0]  r_pos_x;
    logic [DUCK_POS_W-1:0]  r_pos_y;
    logic                   r_flip;
    logic                   r_drain;

    logic                   r_s1_valid;
    logic [SX_W-1:0]        r_s1_sx;
    logic [SY_W-1:0]        r_s1_sy;

    logic                          w_last_px;
    logic signed [DUCK_COORD_W-1:0] w_tx;
    logic signed [DUCK_COORD_W-1:0] w_ty;
    logic                          w_in_bounds;
    logic [DUCK_FB_AW-1:0]         w_fb_addr;
    logic                          w_unused_coords;

    assign w_last_px       = (r_sx == SX_W'(SPR_W - 1)) && (r_sy == SY_W'(SPR_H - 1));
    assign rom_address     = r_addr;
    assign w_unused_coords = ^{w_tx, w_ty};

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (w_last_px) w_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_drain) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_addr  <= '0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_flip  <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pos_x <= pos_x;
                        r_pos_y <= pos_y;
                        r_flip  <= flip_h;
                        r_sx    <= '0;
                        r_sy    <= '0;
                        r_addr  <= '0;
                    end
                end
                RUN: begin
                    // Linear ROM address tracks sy*SPR_W+sx without a multiplier.
                    r_addr  <= r_addr + 1'b1;
                    r_drain <= 1'b0;
                    if (r_sx == SX_W'(SPR_W - 1)) begin
                        r_sx <= '0;
                        r_sy <= r_sy + 1'b1;
                    end else begin
                        r_sx <= r_sx + 1'b1;
                    end
                end
                DRAIN:   r_drain <= ~r_drain;
                default: ;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sx    <= '0;
            r_s1_sy    <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
        end else begin
            r_s1_valid <= (r_state == RUN);
            r_s1_sx    <= r_sx;
            r_s1_sy    <= r_sy;
            fb_we      <= r_s1_valid && (rom_q != TRANSPARENT_IDX) && w_in_bounds;
            fb_addr    <= w_fb_addr;
            fb_data    <= rom_q;
        end
    end

    duck_blit_addr #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .FB_W  (FB_W),
        .FB_H  (FB_H)
    ) u_addr (
        .i_pos_x     (r_pos_x),
        .i_pos_y     (r_pos_y),
        .i_flip_h    (r_flip),
        .i_sx        (r_s1_sx),
        .i_sy        (r_s1_sy),
        .o_tx        (w_tx),
        .o_ty        (w_ty),
        .o_in_bounds (w_in_bounds),
        .o_fb_addr   (w_fb_addr)
    );

endmodule
